// File: rtl/txn_guard_multi.sv
// Per-ID outstanding AXI transaction tracker with length-scaled timeouts (write or read mode).
// Latency: table and status update one cycle after the observed handshake; accept_o is combinational.
// Backpressure: never stalls the bus itself; accept_o drops when the table is full or a timeout is pending.
module txn_guard_multi #(
  parameter int Mode         = 0,
  parameter int MaxTxns      = 8,
  parameter int IdWidth      = 4,
  parameter int CntWidth     = 10,
  parameter int PrescalerDiv = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  input  logic                         req_ready_i,
  input  logic [IdWidth-1:0]           req_id_i,
  input  logic [7:0]                   req_len_i,
  input  logic                         rsp_valid_i,
  input  logic                         rsp_ready_i,
  input  logic [IdWidth-1:0]           rsp_id_i,
  input  logic                         rsp_last_i,
  input  logic [CntWidth-1:0]          budget_base_i,
  input  logic [CntWidth-1:0]          budget_beat_i,
  input  logic                         reset_clear_i,
  output logic                         accept_o,
  output logic [$clog2(MaxTxns+1)-1:0] outstanding_o,
  output logic                         unexpected_rsp_o,
  output logic [IdWidth-1:0]           timeout_id_o,
  output logic                         reset_req_o,
  output logic                         irq_o
);

  localparam int IdxW  = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int OutW  = $clog2(MaxTxns+1);
  localparam int PreW  = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
  localparam int WideW = CntWidth + 10;

  logic [MaxTxns-1:0]  vld_q;
  logic [IdWidth-1:0]  id_q     [MaxTxns];
  logic [IdxW-1:0]     rank_q   [MaxTxns];
  logic [CntWidth-1:0] age_q    [MaxTxns];
  logic [CntWidth-1:0] budget_q [MaxTxns];
  logic [PreW-1:0]     pre_q;
  logic                reset_req_q;
  logic                unexp_q;
  logic [IdWidth-1:0]  tmo_id_q;

  logic                tick;
  logic                alloc_hs;
  logic                rsp_hs;
  logic                hit;
  logic [MaxTxns-1:0]  match;
  logic [MaxTxns-1:0]  same_rsp;
  logic [MaxTxns-1:0]  expired;
  logic                any_exp;
  logic [IdxW-1:0]     free_idx;
  logic [IdxW-1:0]     exp_idx;
  logic [IdxW-1:0]     alloc_rank;
  logic [OutW-1:0]     occ;
  logic [WideW-1:0]    budget_wide;
  logic [CntWidth-1:0] alloc_budget;

  assign tick     = (pre_q == PreW'(PrescalerDiv-1));
  assign accept_o = !(&vld_q) && !reset_req_q;
  assign alloc_hs = req_valid_i && req_ready_i && accept_o;
  assign rsp_hs   = rsp_valid_i && rsp_ready_i && ((Mode == 0) || rsp_last_i) && !reset_req_q;

  // Budget is formed at full width so a long burst cannot wrap to a tiny timeout.
  assign budget_wide  = WideW'(budget_base_i)
                      + (WideW'(req_len_i) + WideW'(1)) * WideW'(budget_beat_i);
  assign alloc_budget = (budget_wide > WideW'({CntWidth{1'b1}})) ? {CntWidth{1'b1}}
                                                                  : budget_wide[CntWidth-1:0];

  always_comb begin
    match    = '0;
    same_rsp = '0;
    expired  = '0;
    for (int i = 0; i < MaxTxns; i++) begin
      same_rsp[i] = vld_q[i] && (id_q[i] == rsp_id_i);
      match[i]    = same_rsp[i] && (rank_q[i] == '0);
      expired[i]  = vld_q[i] && (age_q[i] == budget_q[i]);
    end
  end

  assign hit     = |match;
  assign any_exp = |expired;

  always_comb begin
    free_idx = '0;
    exp_idx  = '0;
    for (int i = MaxTxns-1; i >= 0; i--) begin
      if (!vld_q[i])  free_idx = IdxW'(i);
      if (expired[i]) exp_idx  = IdxW'(i);
    end
  end

  // The entry being retired this cycle no longer counts toward the new entry's rank.
  always_comb begin
    alloc_rank = '0;
    for (int i = 0; i < MaxTxns; i++) begin
      if (vld_q[i] && (id_q[i] == req_id_i) && !(match[i] && rsp_hs))
        alloc_rank = alloc_rank + IdxW'(1);
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < MaxTxns; i++) occ = occ + OutW'(vld_q[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      pre_q       <= '0;
      reset_req_q <= 1'b0;
      unexp_q     <= 1'b0;
      tmo_id_q    <= '0;
      for (int i = 0; i < MaxTxns; i++) begin
        id_q[i]     <= '0;
        rank_q[i]   <= '0;
        age_q[i]    <= '0;
        budget_q[i] <= '0;
      end
    end else begin
      pre_q   <= tick ? '0 : pre_q + PreW'(1);
      unexp_q <= 1'b0;
      if (reset_clear_i) begin
        vld_q       <= '0;
        reset_req_q <= 1'b0;
        tmo_id_q    <= '0;
      end else begin
        unexp_q <= rsp_hs && !hit;
        if (any_exp && !reset_req_q) begin
          reset_req_q <= 1'b1;
          tmo_id_q    <= id_q[exp_idx];
        end
        for (int i = 0; i < MaxTxns; i++) begin
          if (!reset_req_q && tick && vld_q[i] && (age_q[i] < budget_q[i]))
            age_q[i] <= age_q[i] + CntWidth'(1);
          if (rsp_hs && hit && same_rsp[i]) begin
            if (match[i]) vld_q[i]  <= 1'b0;
            else          rank_q[i] <= rank_q[i] - IdxW'(1);
          end
          if (alloc_hs && (free_idx == IdxW'(i))) begin
            vld_q[i]    <= 1'b1;
            id_q[i]     <= req_id_i;
            rank_q[i]   <= alloc_rank;
            age_q[i]    <= '0;
            budget_q[i] <= alloc_budget;
          end
        end
      end
    end
  end

  assign outstanding_o    = occ;
  assign unexpected_rsp_o = unexp_q;
  assign timeout_id_o     = tmo_id_q;
  assign reset_req_o      = reset_req_q;
  assign irq_o            = reset_req_q;

endmodule
